// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/LSU memory arbiter.
// FSM state encoding and grant index encoding.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic GRANT_INSTR = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way combinational grant selection.
// Ports: req_instr/req_data requests, last_grant history, grant winner index.
module arb_rr2
    import mem_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic req_instr,
    input  logic req_data,
    input  logic last_grant,
    output logic grant
);

    always_comb begin
        grant = GRANT_INSTR;
        if (req_instr && req_data) begin
            if (ROUND_ROBIN != 0)
                grant = (last_grant == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
            else
                grant = GRANT_DATA;
        end else if (req_data) begin
            grant = GRANT_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data LSU.
// Ports: instr_* fetch side, data_* load/store side, mem_* memory side.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_read,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_read_data,
    output logic        instr_response,
    output logic        instr_error,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_write_data,
    output logic [31:0] data_read_data,
    output logic        data_response,
    output logic        data_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_response
);

    state_t               state_q, state_d;
    logic                 grant_q, grant_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 arb_grant;
    logic                 mem_read_d, mem_write_d;
    logic [31:0]          mem_address_d, mem_write_data_d;
    logic                 instr_response_d, instr_error_d;
    logic                 data_response_d, data_error_d;
    logic [31:0]          instr_read_data_d, data_read_data_d;
    logic [31:0]          rsp_data;

    arb_rr2 #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_arb (
        .req_instr (instr_read),
        .req_data  (data_read | data_write),
        .last_grant(grant_q),
        .grant     (arb_grant)
    );

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        cnt_d             = cnt_q;
        mem_read_d        = mem_read;
        mem_write_d       = mem_write;
        mem_address_d     = mem_address;
        mem_write_data_d  = mem_write_data;
        instr_read_data_d = instr_read_data;
        data_read_data_d  = data_read_data;
        instr_response_d  = 1'b0;
        instr_error_d     = 1'b0;
        data_response_d   = 1'b0;
        data_error_d      = 1'b0;
        rsp_data          = mem_write ? 32'h0 : mem_read_data;
        unique case (state_q)
            IDLE: begin
                if (instr_read || data_read || data_write) begin
                    grant_d = arb_grant;
                    cnt_d   = '0;
                    state_d = BUSY;
                    if (arb_grant == GRANT_DATA) begin
                        mem_address_d    = data_address;
                        mem_write_data_d = data_write_data;
                        // a store wins over a simultaneous load
                        mem_write_d      = data_write;
                        mem_read_d       = ~data_write;
                    end else begin
                        mem_address_d    = instr_address;
                        mem_write_data_d = 32'h0;
                        mem_write_d      = 1'b0;
                        mem_read_d       = 1'b1;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (mem_response) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                    if (grant_q == GRANT_DATA) begin
                        data_response_d  = 1'b1;
                        data_read_data_d = rsp_data;
                    end else begin
                        instr_response_d  = 1'b1;
                        instr_read_data_d = rsp_data;
                    end
                end else if (TIMEOUT_CYCLES != 0 &&
                             cnt_d == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                    if (grant_q == GRANT_DATA) begin
                        data_response_d  = 1'b1;
                        data_error_d     = 1'b1;
                        data_read_data_d = 32'h0;
                    end else begin
                        instr_response_d  = 1'b1;
                        instr_error_d     = 1'b1;
                        instr_read_data_d = 32'h0;
                    end
                end
            end
            DONE: begin
                // response-low cycle; requests are not sampled here
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            grant_q         <= GRANT_DATA;
            cnt_q           <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= 32'h0;
            mem_write_data  <= 32'h0;
            instr_read_data <= 32'h0;
            data_read_data  <= 32'h0;
            instr_response  <= 1'b0;
            instr_error     <= 1'b0;
            data_response   <= 1'b0;
            data_error      <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            cnt_q           <= cnt_d;
            mem_read        <= mem_read_d;
            mem_write       <= mem_write_d;
            mem_address     <= mem_address_d;
            mem_write_data  <= mem_write_data_d;
            instr_read_data <= instr_read_data_d;
            data_read_data  <= data_read_data_d;
            instr_response  <= instr_response_d;
            instr_error     <= instr_error_d;
            data_response   <= data_response_d;
            data_error      <= data_error_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (round-robin and fixed-priority).
// Drives directed and random traffic against a queue-free reference model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, f_rst_n, mclr, mem_en, stray;
    logic        instr_read, data_read, data_write;
    logic [31:0] instr_address, data_address, data_write_data;

    logic [31:0] instr_read_data, data_read_data;
    logic        instr_response, instr_error, data_response, data_error;
    logic        mem_read, mem_write, mem_response, m_resp;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    logic [31:0] f_instr_read_data, f_data_read_data;
    logic        f_instr_response, f_instr_error;
    logic        f_data_response, f_data_error;
    logic        f_mem_read, f_mem_write, f_mem_response;
    logic [31:0] f_mem_address, f_mem_write_data;
    logic [31:0] f_mem_read_data;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .ROUND_ROBIN(1), .TIMEOUT_CYCLES(4), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_read(instr_read), .instr_address(instr_address),
        .instr_read_data(instr_read_data),
        .instr_response(instr_response), .instr_error(instr_error),
        .data_read(data_read), .data_write(data_write),
        .data_address(data_address), .data_write_data(data_write_data),
        .data_read_data(data_read_data),
        .data_response(data_response), .data_error(data_error),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_response(mem_response)
    );

    mem_arbiter #(
        .ROUND_ROBIN(0), .TIMEOUT_CYCLES(4), .CNT_WIDTH(8)
    ) dut_fp (
        .clk(clk), .rst_n(f_rst_n),
        .instr_read(instr_read), .instr_address(instr_address),
        .instr_read_data(f_instr_read_data),
        .instr_response(f_instr_response), .instr_error(f_instr_error),
        .data_read(data_read), .data_write(data_write),
        .data_address(data_address), .data_write_data(data_write_data),
        .data_read_data(f_data_read_data),
        .data_response(f_data_response), .data_error(f_data_error),
        .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_address(f_mem_address), .mem_write_data(f_mem_write_data),
        .mem_read_data(f_mem_read_data), .mem_response(f_mem_response)
    );

    // unwritten words read back as (low address byte + 3)
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {24'h0, a[7:0]} + 32'd3;
    endfunction

    logic [31:0] mstore [64];
    logic        mvalid [64];

    always @(posedge clk) begin
        m_resp <= 1'b0;
        if (mclr) begin
            for (int i = 0; i < 64; i++) mvalid[i] <= 1'b0;
            mem_read_data <= 32'h0;
        end else if (mem_en && (mem_read || mem_write) && !m_resp) begin
            m_resp <= 1'b1;
            if (mem_write) begin
                mstore[mem_address[7:2]] <= mem_write_data;
                mvalid[mem_address[7:2]] <= 1'b1;
                mem_read_data <= 32'hA5A5_A5A5;
            end else begin
                mem_read_data <= mvalid[mem_address[7:2]] ?
                    mstore[mem_address[7:2]] : dflt(mem_address);
            end
        end
    end
    assign mem_response = m_resp | stray;

    always @(posedge clk) begin
        f_mem_response <= 1'b0;
        if (!mclr && mem_en && (f_mem_read || f_mem_write) && !f_mem_response)
            f_mem_response <= 1'b1;
    end
    assign f_mem_read_data = 32'h0;

    // reference model state
    logic [31:0] ref_mem [int];
    bit          ref_last_data;
    logic [31:0] ref_i_data, ref_d_data;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int k = int'(a[7:2]);
        return ref_mem.exists(k) ? ref_mem[k] : dflt(a);
    endfunction

    function automatic bit pick(input bit ri, input bit rd,
                                input bit last_d, input bit rr);
        if (ri && rd) return rr ? !last_d : 1'b1;
        return rd;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input bit ri, input bit rd, input bit wr,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] wd);
        bit          dwin, got;
        logic [31:0] exp;
        instr_read      = ri;
        data_read       = rd;
        data_write      = wr;
        instr_address   = ia;
        data_address    = da;
        data_write_data = wd;
        dwin = pick(ri, rd | wr, ref_last_data, 1'b1);
        if (dwin) exp = wr ? 32'h0 : ref_rd(da);
        else      exp = ref_rd(ia);
        if (dwin && wr) ref_mem[int'(da[7:2])] = wd;
        ref_last_data = dwin;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            got = instr_response || data_response;
        end
        chk1("txn_resp_seen", got, 1'b1);
        if (got) begin
            if (dwin) ref_d_data = exp;
            else      ref_i_data = exp;
            chk1("txn_instr_resp", instr_response, !dwin);
            chk1("txn_data_resp", data_response, dwin);
            chk1("txn_err", instr_error | data_error, 1'b0);
            chk32("txn_instr_rdata", instr_read_data, ref_i_data);
            chk32("txn_data_rdata", data_read_data, ref_d_data);
        end
        instr_read = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    initial begin
        bit ri, rd, wr;
        bit last0, last1, dreq, e0, e1, prev0, cur0;
        int n0, n1, last_rise;

        rst_n = 1'b0; f_rst_n = 1'b0; mclr = 1'b1;
        mem_en = 1'b1; stray = 1'b0;
        instr_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
        instr_address = 32'h0; data_address = 32'h0;
        data_write_data = 32'h0;
        ref_last_data = 1'b1; ref_i_data = 32'h0; ref_d_data = 32'h0;
        tick(); tick();
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk32("rst_mem_addr", mem_address, 32'h0);
        chk1("rst_resp", instr_response | data_response, 1'b0);
        chk32("rst_rdata", instr_read_data | data_read_data, 32'h0);
        rst_n = 1'b1; mclr = 1'b0;
        tick();

        // single fetch with exact latency
        instr_read = 1'b1; instr_address = 32'h10;
        tick();
        chk1("f_mem_read_1", mem_read, 1'b1);
        chk32("f_mem_addr", mem_address, 32'h10);
        chk1("f_mem_write", mem_write, 1'b0);
        tick();
        chk1("f_mem_read_2", mem_read, 1'b1);
        chk1("f_early_resp", instr_response, 1'b0);
        tick();
        chk1("f_resp", instr_response, 1'b1);
        chk32("f_rdata", instr_read_data, 32'h13);
        chk1("f_mem_read_drop", mem_read, 1'b0);
        chk1("f_data_silent", data_response, 1'b0);
        ref_i_data = 32'h13; ref_last_data = 1'b0;
        instr_read = 1'b0;
        tick();
        chk1("f_resp_clear", instr_response, 1'b0);
        tick();

        // store, store with load also high, then load
        data_write = 1'b1; data_address = 32'h20;
        data_write_data = 32'hDEAD_BEEF;
        tick();
        chk1("st_mem_write", mem_write, 1'b1);
        chk1("st_mem_read", mem_read, 1'b0);
        chk32("st_wdata", mem_write_data, 32'hDEAD_BEEF);
        tick(); tick();
        chk1("st_resp", data_response, 1'b1);
        chk32("st_rdata", data_read_data, 32'h0);
        ref_mem[8] = 32'hDEAD_BEEF; ref_d_data = 32'h0; ref_last_data = 1'b1;
        data_write = 1'b0;
        tick(); tick();
        data_write = 1'b1; data_read = 1'b1; data_address = 32'h24;
        data_write_data = 32'h1234_5678;
        tick();
        chk1("rw_mem_write", mem_write, 1'b1);
        chk1("rw_mem_read", mem_read, 1'b0);
        tick(); tick();
        chk1("rw_resp", data_response, 1'b1);
        ref_mem[9] = 32'h1234_5678;
        data_write = 1'b0; data_read = 1'b0;
        tick(); tick();
        txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0);
        tick(); tick();

        // watchdog timeout, then stray response ignored
        mem_en = 1'b0;
        data_read = 1'b1; data_address = 32'h30;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("to_busy_read", mem_read, 1'b1);
            chk1("to_busy_resp", data_response, 1'b0);
        end
        tick();
        chk1("to_resp", data_response, 1'b1);
        chk1("to_err", data_error, 1'b1);
        chk32("to_rdata", data_read_data, 32'h0);
        chk1("to_mem_read", mem_read, 1'b0);
        chk1("to_instr_silent", instr_response, 1'b0);
        ref_d_data = 32'h0; ref_last_data = 1'b1;
        data_read = 1'b0; stray = 1'b1;
        tick();
        chk1("stray_done", data_response | data_error, 1'b0);
        tick();
        chk1("stray_idle", data_response | instr_response, 1'b0);
        chk1("stray_mem", mem_read | mem_write, 1'b0);
        stray = 1'b0; mem_en = 1'b1;
        tick();

        // reset in the middle of BUSY
        mem_en = 1'b0;
        instr_read = 1'b1; instr_address = 32'h14;
        tick();
        chk1("mr_busy", mem_read, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("mr_mem_read", mem_read, 1'b0);
        chk32("mr_mem_addr", mem_address, 32'h0);
        chk32("mr_rdata", instr_read_data, 32'h0);
        ref_i_data = 32'h0; ref_d_data = 32'h0; ref_last_data = 1'b1;
        instr_read = 1'b0;
        tick();
        mem_en = 1'b1; rst_n = 1'b1;
        tick();
        txn(1'b1, 1'b1, 1'b0, 32'h14, 32'h24, 32'h0);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            ri = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!ri && !rd && !wr) ri = 1'b1;
            txn(ri, rd, wr, $urandom & 32'hFC, $urandom & 32'hFC, $urandom);
        end
        tick(); tick();

        // held tie from reset on both arbiters
        rst_n = 1'b0; f_rst_n = 1'b0;
        instr_read = 1'b1; data_read = 1'b1;
        instr_address = 32'h40; data_address = 32'h44;
        tick();
        rst_n = 1'b1; f_rst_n = 1'b1;
        last0 = 1'b1; last1 = 1'b1; n0 = 0; n1 = 0;
        last_rise = -1; prev0 = 1'b0;
        for (int e = 1; e <= 28; e++) begin
            tick();
            dreq = (e - 2) <= 16;
            if (instr_response || data_response) begin
                e0 = pick(1'b1, dreq, last0, 1'b1);
                chk1("rr_data_grant", data_response, e0);
                chk1("rr_instr_grant", instr_response, !e0);
                last0 = e0; n0++;
            end
            if (f_instr_response || f_data_response) begin
                e1 = pick(1'b1, dreq, last1, 1'b0);
                chk1("fp_data_grant", f_data_response, e1);
                chk1("fp_instr_grant", f_instr_response, !e1);
                last1 = e1; n1++;
            end
            cur0 = mem_read | mem_write;
            if (cur0 && !prev0) begin
                if (last_rise >= 0)
                    chk32("rr_spacing", 32'(e - last_rise), 32'd4);
                last_rise = e;
            end
            prev0 = cur0;
            if (e == 16) data_read = 1'b0;
        end
        chk32("rr_count", 32'(n0), 32'd7);
        chk32("fp_count", 32'(n1), 32'd7);
        instr_read = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
